// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage RV32 pipe: stall/flush generation,
// EX forwarding selects, memory-wait FSM with watchdog, and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemWait,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] LdStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [11:0] TO_LIM = 12'(TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [11:0]      r_wcnt, w_wcnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_ld_cnt, r_mem_cnt, r_fl_cnt;
  logic             w_mem_stall, w_lw_stall, w_br_flush;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m,
                                         input logic [4:0] rd_m,
                                         input logic       rw_w,
                                         input logic [4:0] rd_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  // A memory wait freezes everything, so it masks the load-use and branch terms.
  assign w_mem_stall = MemReqM & ~MemReadyM;
  assign w_lw_stall  = ~w_mem_stall & RegWriteE & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                       ((RdE == Rs1D) | (RdE == Rs2D));
  assign w_br_flush  = ~w_mem_stall & PCSrcE;

  assign StallF    = ~rst & (w_lw_stall | w_mem_stall);
  assign StallD    = ~rst & (w_lw_stall | w_mem_stall);
  assign StallE    = ~rst & w_mem_stall;
  assign StallM    = ~rst & w_mem_stall;
  assign FlushW    = ~rst & w_mem_stall;
  assign FlushD    = ~rst & w_br_flush;
  assign FlushE    = ~rst & (w_lw_stall | w_br_flush);
  assign ForwardAE = rst ? 2'b00 : fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = rst ? 2'b00 : fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign MemWait     = (r_state == S_WAIT);
  assign MemTimeout  = r_timeout;
  assign LdStallCnt  = r_ld_cnt;
  assign MemStallCnt = r_mem_cnt;
  assign FlushCnt    = r_fl_cnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = 12'd1;
        end
      end
      S_WAIT: begin
        if (w_mem_stall) begin
          if (r_wcnt != 12'hFFF) w_wcnt_nxt = r_wcnt + 12'd1;
          if (r_wcnt == TO_LIM)  w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
          w_wcnt_nxt  = 12'd0;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wcnt_nxt  = 12'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_wcnt    <= 12'd0;
      r_timeout <= 1'b0;
      r_ld_cnt  <= '0;
      r_mem_cnt <= '0;
      r_fl_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_ld_cnt  <= sat_inc(r_ld_cnt, w_lw_stall);
      r_mem_cnt <= sat_inc(r_mem_cnt, w_mem_stall);
      r_fl_cnt  <= sat_inc(r_fl_cnt, w_br_flush);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model expectations per cycle,
// a negedge monitor pops and compares every output.
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemWait, MemTimeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] LdStallCnt, MemStallCnt, FlushCnt;

  hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemWait(MemWait), .MemTimeout(MemTimeout),
    .LdStallCnt(LdStallCnt), .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       rwe, pcsrc;
    logic [4:0] rdm;
    logic       rwm, mreq, mrdy;
    logic [4:0] rdw;
    logic       rww;
  } stim_t;

  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
    logic       mw, mt;
    logic [15:0] ld, ms, fl;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: length of the current memory-stall run, sticky flag, counters.
  int m_run = 0;
  bit m_to  = 1'b0;
  int m_ld = 0, m_ms = 0, m_fl = 0;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input stim_t s, input bit push);
    exp_t e;
    bit mem, lw, br;
    @(posedge clk);
    #1;
    rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
    ResultSrcE = s.rsrc; RegWriteE = s.rwe; PCSrcE = s.pcsrc; RdM = s.rdm; RegWriteM = s.rwm;
    MemReqM = s.mreq; MemReadyM = s.mrdy; RdW = s.rdw; RegWriteW = s.rww;
    mem = s.mreq && !s.mrdy;
    lw  = !mem && s.rwe && s.rsrc == 2'b01 && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
    br  = !mem && s.pcsrc;
    e = '0;
    if (!s.rst) begin
      e.sf = lw || mem; e.sd = lw || mem;
      e.se = mem; e.sm = mem; e.fw = mem;
      e.fd = br; e.fe = lw || br;
      e.fa = fwd_ref(s.rs1e, s); e.fb = fwd_ref(s.rs2e, s);
    end
    e.mw = (m_run > 0);
    e.mt = m_to;
    e.ld = 16'(m_ld); e.ms = 16'(m_ms); e.fl = 16'(m_fl);
    if (push) q.push_back(e);
    if (s.rst) begin
      m_run = 0; m_to = 1'b0; m_ld = 0; m_ms = 0; m_fl = 0;
    end else begin
      if (mem && m_run == TO) m_to = 1'b1;
      m_run = mem ? ((m_run < 4095) ? m_run + 1 : 4095) : 0;
      if (lw  && m_ld < CMAX) m_ld++;
      if (mem && m_ms < CMAX) m_ms++;
      if (br  && m_fl < CMAX) m_fl++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("StallF", StallF, e.sf);
      chk("StallD", StallD, e.sd);
      chk("StallE", StallE, e.se);
      chk("StallM", StallM, e.sm);
      chk("FlushD", FlushD, e.fd);
      chk("FlushE", FlushE, e.fe);
      chk("FlushW", FlushW, e.fw);
      chk("ForwardAE", ForwardAE, e.fa);
      chk("ForwardBE", ForwardBE, e.fb);
      chk("MemWait", MemWait, e.mw);
      chk("MemTimeout", MemTimeout, e.mt);
      chk("LdStallCnt", LdStallCnt, e.ld);
      chk("MemStallCnt", MemStallCnt, e.ms);
      chk("FlushCnt", FlushCnt, e.fl);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    rst = 1'b1; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = '0;
    RegWriteE = 0; PCSrcE = 0; RdM = '0; RegWriteM = 0; MemReqM = 0; MemReadyM = 0;
    RdW = '0; RegWriteW = 0;
    step(s, 1'b0);
    step(s, 1'b1);

    // Forwarding priority
    s = idle(); s.rdm = 5; s.rdw = 5; s.rs1e = 5; s.rwm = 1; s.rww = 1; s.rs2e = 5;
    step(s, 1'b1);
    s.rwm = 0; step(s, 1'b1);
    s.rs1e = 0; step(s, 1'b1);

    // Load-use, then branch alone and combined with load-use
    s = idle(); s.rsrc = 2'b01; s.rwe = 1; s.rde = 3; s.rs2d = 3;
    step(s, 1'b1);
    step(idle(), 1'b1);
    s = idle(); s.pcsrc = 1; step(s, 1'b1);
    s.rsrc = 2'b01; s.rwe = 1; s.rde = 3; s.rs2d = 3; step(s, 1'b1);

    // Memory wait with a pending branch
    s = idle(); s.mreq = 1; s.pcsrc = 1;
    repeat (3) step(s, 1'b1);
    s.mrdy = 1; step(s, 1'b1);
    repeat (2) step(idle(), 1'b1);

    // Timeout after a long wait, sticky until reset
    s = idle(); s.mreq = 1;
    repeat (6) step(s, 1'b1);
    s.mrdy = 1; step(s, 1'b1);
    repeat (2) step(idle(), 1'b1);
    s = idle(); s.rst = 1; step(s, 1'b1);
    step(idle(), 1'b1);

    // Counter saturation
    s = idle(); s.rsrc = 2'b01; s.rwe = 1; s.rde = 7; s.rs1d = 7;
    repeat (20) step(s, 1'b1);
    step(idle(), 1'b1);

    // Reset in the middle of a wait
    s = idle(); s.mreq = 1;
    repeat (2) step(s, 1'b1);
    s.rst = 1; step(s, 1'b1);
    s.rst = 0; step(s, 1'b1);
    step(idle(), 1'b1);

    // Randomized traffic with small register indices to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      s.rst   = ($urandom_range(0, 59) == 0);
      s.rs1d  = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e  = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde   = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw   = 5'($urandom_range(0, 3));
      s.rsrc  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      s.rwe   = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
      s.rww   = 1'($urandom_range(0, 1));
      s.pcsrc = ($urandom_range(0, 4) == 0);
      s.mreq  = ($urandom_range(0, 3) != 0);
      s.mrdy  = ($urandom_range(0, 2) == 0);
      step(s, 1'b1);
    end

    @(negedge clk);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
